// File: rtl/gf_pkg.sv
// gf_pkg: shared defaults, FSM state type and latency constants for the GF(2^M) datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gf_pkg;

   // Default field: GF(2^8) reduced by x^8 + x^4 + x^3 + x + 1.
   localparam int           M_C    = 8;
   localparam logic [M_C:0] POLY_C = 9'h11B;

   typedef enum logic [2:0] {
      IDLE,
      SQR,
      MUL,
      FIN,
      DONE
   } gf_div_state_t;

   // Handshake edge to first edge with egr_valid high.
   // Serial squaring: (2M-1) multiplies of M cycles, plus one.
   localparam int GF_DIV_LAT_C     = (2 * M_C - 1) * M_C + 1;
   // Combinational squaring: M-1 one-cycle squarings, M multiplies, plus one.
   localparam int GF_DIV_LAT_SQC_C = (M_C - 1) + M_C * M_C + 1;

endpackage

// File: rtl/gf_div_serial_if.sv
// gf_div_serial_if: operand ingress and quotient egress bundle of the serial GF divider.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; the divider is the slave modport.
// Ports: ing_valid/ing_ready/ing_dividend/ing_divisor (operands in),
//        egr_valid/egr_ready/egr_quotient/egr_div_by_zero (result out).
interface gf_div_serial_if #(
   parameter int M = gf_pkg::M_C
);
   logic         ing_valid;
   logic         ing_ready;
   logic [M-1:0] ing_dividend;
   logic [M-1:0] ing_divisor;
   logic         egr_valid;
   logic         egr_ready;
   logic [M-1:0] egr_quotient;
   logic         egr_div_by_zero;

   // Operand source / result sink side.
   modport master (
      output ing_valid, ing_dividend, ing_divisor, egr_ready,
      input  ing_ready, egr_valid, egr_quotient, egr_div_by_zero
   );

   // Divider side.
   modport slave (
      input  ing_valid, ing_dividend, ing_divisor, egr_ready,
      output ing_ready, egr_valid, egr_quotient, egr_div_by_zero
   );
endinterface

// File: rtl/gf_mul_serial.sv
// gf_mul_serial: bit-serial GF(2^M) multiplier, Horner MSB-first, operands latched on start.
// Latency: start edge performs step 1; done pulses the cycle after step M (M cycles start to done edge).
// Backpressure: none; a new start restarts the multiply. Requires M >= 2.
// Ports: clk, rst_n (async active-low), start, a, b -> done (1-cycle pulse), product (held until next start).
module gf_mul_serial #(
   parameter int         M    = gf_pkg::M_C,
   parameter logic [M:0] POLY = gf_pkg::POLY_C
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   output logic         done,
   output logic [M-1:0] product
);

   localparam int CW = $clog2(M);

   logic [M-1:0]  a_q;
   logic [M-1:0]  b_q;     // remaining multiplier bits, next one at the MSB
   logic [M-1:0]  acc;
   logic [CW-1:0] cnt;     // steps still to run after the start edge

   // One Horner step: acc*x mod POLY, then add a if the current b bit is set.
   function automatic logic [M-1:0] step(input logic [M-1:0] acc_in,
                                         input logic         bit_in,
                                         input logic [M-1:0] a_in);
      logic [M:0] sh;
      sh = {acc_in, 1'b0};
      if (sh[M]) sh = sh ^ POLY;
      return sh[M-1:0] ^ (bit_in ? a_in : '0);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         acc  <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // Accumulator starts from zero, so the first step reduces to b[M-1] ? a : 0.
            a_q <= a;
            b_q <= {b[M-2:0], 1'b0};
            acc <= step('0, b[M-1], a);
            cnt <= CW'(M - 1);
         end else if (cnt != '0) begin
            acc <= step(acc, b_q[M-1], a_q);
            b_q <= {b_q[M-2:0], 1'b0};
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) done <= 1'b1;
         end
      end
   end

   assign product = acc;

endmodule

// File: rtl/gf_div_serial.sv
// gf_div_serial: GF(2^M) divider, quotient = a * b^(2^M-2), one division in flight on a shared serial multiplier.
// Latency: (2M-1)*M+1 cycles (121 @M=8); with GF_DIV_SQUARE_COMB_EN (M-1)+M*M+1 (72 @M=8); b=0 answers in 1.
// Backpressure: ing_ready only in IDLE; result held in DONE until egr_ready, ingress reopens the next cycle.
// Ports: clk, rst_n (async active-low), bus (gf_div_serial_if.slave: ing_* operands, egr_* result).
// Build option: define GF_DIV_SQUARE_COMB_EN for a one-cycle combinational squarer.
module gf_div_serial
   import gf_pkg::*;
#(
   parameter int         M    = M_C,
   parameter logic [M:0] POLY = POLY_C
) (
   input  logic           clk,
   input  logic           rst_n,
   gf_div_serial_if.slave bus
);

   localparam int            CW      = $clog2(M);
   localparam logic [CW-1:0] SQ_LAST = CW'(M - 1);

   gf_div_state_t state, state_nxt;

   logic [M-1:0]  a_q;     // dividend
   logic [M-1:0]  s_q;     // b^(2^i)
   logic [M-1:0]  r_q;     // running product of the squares
   logic [M-1:0]  q_q;
   logic          dbz_q;
   logic [CW-1:0] sq_cnt;  // squarings completed
   logic          live_q;  // low through reset and the first cycle after release

   logic          hs;
   logic          mul_start;
   logic          mul_done;
   logic [M-1:0]  mul_a;
   logic [M-1:0]  mul_b;
   logic [M-1:0]  mul_p;
   logic [M-1:0]  s_sq;    // next value of s when leaving SQR

`ifdef GF_DIV_SQUARE_COMB_EN
   localparam bit SQC_EN = 1'b1;

   // Squaring is linear: spread bit i to bit 2i, then fold the top bits back with POLY.
   function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] x);
      logic [2*M-2:0] w;
      w = '0;
      for (int i = 0; i < M; i++) w[2*i] = x[i];
      for (int k = 2*M-2; k >= M; k--)
         if (w[k]) w[k -: M+1] = w[k -: M+1] ^ POLY;
      return w[M-1:0];
   endfunction

   assign s_sq = gf_sqr(s_q);
`else
   localparam bit SQC_EN = 1'b0;

   assign s_sq = mul_p;
`endif

   assign hs = bus.ing_valid && bus.ing_ready;

   gf_mul_serial #(.M(M), .POLY(POLY)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (mul_a),
      .b       (mul_b),
      .done    (mul_done),
      .product (mul_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // The next multiply is launched on the same edge that retires the previous one,
   // so operands come straight from the multiplier output where the register
   // would still hold the old value.
   always_comb begin
      state_nxt = state;
      mul_start = 1'b0;
      mul_a     = s_q;
      mul_b     = s_q;
      case (state)
         IDLE: begin
            if (hs) begin
               if (bus.ing_divisor == '0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = SQR;
                  mul_start = !SQC_EN;
                  mul_a     = bus.ing_divisor;
                  mul_b     = bus.ing_divisor;
               end
            end
         end
         SQR: begin
            if (SQC_EN || mul_done) begin
               state_nxt = MUL;
               mul_start = 1'b1;
               mul_a     = r_q;
               mul_b     = s_sq;
            end
         end
         MUL: begin
            if (mul_done) begin
               if (sq_cnt < SQ_LAST) begin
                  state_nxt = SQR;
                  mul_start = !SQC_EN;
               end else begin
                  state_nxt = FIN;
                  mul_start = 1'b1;
                  mul_a     = a_q;
                  mul_b     = mul_p;
               end
            end
         end
         FIN: begin
            if (mul_done) state_nxt = DONE;
         end
         DONE: begin
            if (bus.egr_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         s_q    <= '0;
         r_q    <= '0;
         q_q    <= '0;
         dbz_q  <= 1'b0;
         sq_cnt <= '0;
         live_q <= 1'b0;
      end else begin
         live_q <= 1'b1;
         case (state)
            IDLE: begin
               if (hs) begin
                  a_q    <= bus.ing_dividend;
                  s_q    <= bus.ing_divisor;
                  r_q    <= M'(1);
                  sq_cnt <= '0;
                  if (bus.ing_divisor == '0) begin
                     q_q   <= '0;
                     dbz_q <= 1'b1;
                  end
               end
            end
            SQR: begin
               if (state_nxt == MUL) begin
                  s_q    <= s_sq;
                  sq_cnt <= sq_cnt + 1'b1;
               end
            end
            MUL: begin
               if (mul_done) r_q <= mul_p;
            end
            FIN: begin
               if (mul_done) begin
                  q_q   <= mul_p;
                  dbz_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ing_ready       = live_q && (state == IDLE);
   assign bus.egr_valid       = (state == DONE);
   assign bus.egr_quotient    = q_q;
   assign bus.egr_div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf_div_serial.sv
// tb_gf_div_serial: directed divisions through gf_div_serial plus a standalone gf_mul_serial check.
// Stimulus pushes expected results into queues; negedge monitors pop and compare as results appear.
module tb_gf_div_serial;

`ifdef GF_DIV_SQUARE_COMB_EN
   localparam int LAT = 72;
`else
   localparam int LAT = 121;
`endif
   localparam int MW = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   gf_div_serial_if #(.M(MW)) bus ();

   gf_div_serial #(.M(MW), .POLY(9'h11B)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic          m_start;
   logic [MW-1:0] m_a;
   logic [MW-1:0] m_b;
   logic          m_done;
   logic [MW-1:0] m_p;

   gf_mul_serial #(.M(MW), .POLY(9'h11B)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (m_start),
      .a       (m_a),
      .b       (m_b),
      .done    (m_done),
      .product (m_p)
   );

   typedef struct { int q; bit dz; int lat; } exp_t;
   typedef struct { int p; int s; } mexp_t;

   exp_t  exp_q[$];
   int    hs_q[$];
   mexp_t mexp_q[$];

   exp_t  e;
   mexp_t me;
   int    h;
   bit    prev_vld = 1'b0;
   bit    busy = 1'b0;
   bit    accepted_prev = 1'b0;
   int    busy_rdy = 0;
   int    held_q = 0;
   int    held_dz = 0;

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference multiply, LSB-first shift-and-add over GF(2^8) mod 0x11B.
   function automatic logic [7:0] sw_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = x;
      bb = y;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         bb = bb >> 1;
         aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      end
      return p;
   endfunction

   // Divider monitor.
   always @(negedge clk) begin
      if (!rst_n) begin
         hs_q.delete();
         prev_vld      = 1'b0;
         busy          = 1'b0;
         accepted_prev = 1'b0;
         busy_rdy      = 0;
      end else begin
         if (accepted_prev) chk("ready_after_accept", int'(bus.ing_ready), 1);
         accepted_prev = 1'b0;
         if (busy && bus.ing_ready) busy_rdy++;
         if (bus.egr_valid && !prev_vld) begin
            if (exp_q.size() == 0 || hs_q.size() == 0) begin
               fail_now($sformatf("unexpected_result q=%0d dz=%0d", bus.egr_quotient, bus.egr_div_by_zero));
            end else begin
               e = exp_q.pop_front();
               h = hs_q.pop_front();
               chk("quotient", int'(bus.egr_quotient), e.q);
               chk("div_by_zero", int'(bus.egr_div_by_zero), int'(e.dz));
               chk("latency", cyc - h + 1, e.lat);
            end
            held_q  = int'(bus.egr_quotient);
            held_dz = int'(bus.egr_div_by_zero);
         end else if (bus.egr_valid) begin
            chk("hold_quotient", int'(bus.egr_quotient), held_q);
            chk("hold_div_by_zero", int'(bus.egr_div_by_zero), held_dz);
         end
         if (bus.egr_valid && bus.egr_ready) begin
            chk("ready_while_busy_cycles", busy_rdy, 0);
            busy          = 1'b0;
            busy_rdy      = 0;
            accepted_prev = 1'b1;
         end
         if (bus.ing_valid && bus.ing_ready) begin
            hs_q.push_back(cyc + 1);
            busy = 1'b1;
         end
         prev_vld = bus.egr_valid;
      end
   end

   // Multiplier monitor.
   always @(negedge clk) begin
      if (rst_n && m_done) begin
         if (mexp_q.size() == 0) begin
            fail_now($sformatf("unexpected_mul_done p=%0d", m_p));
         end else begin
            me = mexp_q.pop_front();
            chk("mul_product", int'(m_p), me.p);
            chk("mul_latency", cyc - me.s + 1, MW);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge, ing_valid left high.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input bit edz, input int lat, input bit push);
      bit ok;
      exp_t x;
      ok = 1'b0;
      if (push) begin
         x.q   = int'(eq);
         x.dz  = edz;
         x.lat = lat;
         exp_q.push_back(x);
      end
      bus.ing_valid    = 1'b1;
      bus.ing_dividend = a;
      bus.ing_divisor  = b;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         ok = bus.ing_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) fail_now($sformatf("ingress_timeout a=%0d b=%0d", a, b));
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || busy) fail_now("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic mul_issue(input logic [7:0] x, input logic [7:0] y, input logic [7:0] expv);
      mexp_t me_l;
      int n;
      me_l.p = int'(expv);
      me_l.s = cyc + 1;
      mexp_q.push_back(me_l);
      m_a     = x;
      m_b     = y;
      m_start = 1'b1;
      @(posedge clk);
      #1;
      m_start = 1'b0;
      n = 0;
      while (mexp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (mexp_q.size() != 0) begin
         fail_now("mul_done_timeout");
         mexp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] x;
      logic [7:0] y;
      int n;

      rst_n            = 1'b1;
      bus.ing_valid    = 1'b0;
      bus.ing_dividend = '0;
      bus.ing_divisor  = '0;
      bus.egr_ready    = 1'b1;
      m_start          = 1'b0;
      m_a              = '0;
      m_b              = '0;
      #3 rst_n = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk);
      chk("reset_ing_ready", int'(bus.ing_ready), 0);
      chk("reset_egr_valid", int'(bus.egr_valid), 0);
      chk("reset_quotient", int'(bus.egr_quotient), 0);
      chk("reset_div_by_zero", int'(bus.egr_div_by_zero), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ing_ready_after_release", int'(bus.ing_ready), 1);
      @(posedge clk);
      #1;

      // Single division, egress always ready.
      issue(8'd8, 8'd46, 8'd103, 1'b0, LAT, 1'b1);
      bus.ing_valid = 1'b0;
      drain(400);

      // Back-to-back stream with ing_valid held high.
      issue(8'd229, 8'd79, 8'd140, 1'b0, LAT, 1'b1);
      issue(8'd64, 8'd3, 8'd201, 1'b0, LAT, 1'b1);
      issue(8'd171, 8'd16, 8'd27, 1'b0, LAT, 1'b1);
      bus.ing_valid = 1'b0;
      drain(600);

      // Zero dividend runs the full sequence; zero divisor answers at once.
      issue(8'd0, 8'd105, 8'd0, 1'b0, LAT, 1'b1);
      bus.ing_valid = 1'b0;
      drain(400);
      issue(8'd77, 8'd0, 8'd0, 1'b1, 1, 1'b1);
      bus.ing_valid = 1'b0;
      drain(400);

      // Egress stall for 20 cycles.
      bus.egr_ready = 1'b0;
      issue(8'd136, 8'd248, 8'd103, 1'b0, LAT, 1'b1);
      bus.ing_valid = 1'b0;
      n = 0;
      while (!bus.egr_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!bus.egr_valid) fail_now("stall_result_timeout");
      repeat (20) @(posedge clk);
      #1;
      bus.egr_ready = 1'b1;
      drain(400);

      // Reset in the middle of a division: no result, outputs cleared at once.
      issue(8'd214, 8'd48, 8'd26, 1'b0, LAT, 1'b0);
      bus.ing_valid = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_ing_ready", int'(bus.ing_ready), 0);
      chk("abort_egr_valid", int'(bus.egr_valid), 0);
      chk("abort_quotient", int'(bus.egr_quotient), 0);
      chk("abort_div_by_zero", int'(bus.egr_div_by_zero), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(8'd214, 8'd48, 8'd26, 1'b0, LAT, 1'b1);
      bus.ing_valid = 1'b0;
      drain(400);

      // Standalone multiplier: directed, then random against the reference.
      mul_issue(8'd3, 8'd133, 8'd148);
      mul_issue(8'd147, 8'd26, 8'd58);
      for (int i = 0; i < 16; i++) begin
         x = 8'($urandom_range(0, 255));
         y = 8'($urandom_range(0, 255));
         mul_issue(x, y, sw_mul(x, y));
      end

      repeat (5) @(posedge clk);
      chk("results_outstanding", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
